// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared definitions for the byte-wide RAM port arbiter.
//                These include state and size encodings, the IO address
//                window, the data word type and a size-to-last-byte helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef logic [31:0] DATA_TYPE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Address bits [17:16] equal to this value select the UART window.
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    localparam logic LAST_IF  = 1'b0;
    localparam logic LAST_LSB = 1'b1;

    // Index of the final byte of a transfer. The unused size code is
    // treated as a full word.
    function automatic logic [1:0] size_to_last(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_last = 2'd0;
            SZ_HALF: size_to_last = 2'd1;
            default: size_to_last = 2'd3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Request, completion and RAM-port signals of the arbiter.
//                The slave modport is the arbiter side. The master modport
//                is the environment side (fetcher, LSB, ROB, RAM, UART).
//  Ports       : rdy, fetch req/done, LSB req/done, ROB flush,
//                RAM din/dout/addr/wr, io_buffer_full
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic        rdy;
    logic        in_if_flag;
    DATA_TYPE    in_if_pc;
    logic        out_if_flag;
    DATA_TYPE    out_if_inst;
    logic        in_lsb_flag;
    logic        in_lsb_wr;
    DATA_TYPE    in_lsb_addr;
    logic [1:0]  in_lsb_size;
    DATA_TYPE    in_lsb_data;
    logic        out_lsb_flag;
    DATA_TYPE    out_lsb_data;
    logic        in_rob_xbp;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    DATA_TYPE    mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  rdy, in_if_flag, in_if_pc, in_lsb_flag, in_lsb_wr, in_lsb_addr,
               in_lsb_size, in_lsb_data, in_rob_xbp, mem_din, io_buffer_full,
        output out_if_flag, out_if_inst, out_lsb_flag, out_lsb_data,
               mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, in_if_flag, in_if_pc, in_lsb_flag, in_lsb_wr, in_lsb_addr,
               in_lsb_size, in_lsb_data, in_rob_xbp, mem_din, io_buffer_full,
        input  out_if_flag, out_if_inst, out_lsb_flag, out_lsb_data,
               mem_dout, mem_a, mem_wr
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares a single byte-wide RAM port between instruction
//                fetch (4-byte reads) and the LSB (1/2/4-byte loads and
//                stores). Multi-byte transfers are sequenced one byte per
//                cycle, little-endian. A ROB flush cancels fetches only.
//  Ports       : clk, rst (sync, active-high), bus (mem_arbiter_if.slave)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    state_e     state_q;
    logic       last_served_q;
    logic       if_pend_q, lsb_pend_q;
    DATA_TYPE   if_pc_q;
    logic       lsb_wr_q;
    DATA_TYPE   lsb_addr_q, lsb_data_q;
    logic [1:0] lsb_size_q;
    logic [1:0] cnt_q, last_q;
    logic       io_q;
    DATA_TYPE   asm_q, wbuf_q;
    logic       out_if_flag_q, out_lsb_flag_q;
    DATA_TYPE   out_if_inst_q, out_lsb_data_q;
    DATA_TYPE   mem_a_q;
    logic [7:0] mem_dout_q;
    logic       mem_wr_q;

    // Request resolution: a pulse from a requester that is already pending
    // or in flight is ignored, and a fetch pulse coinciding with a flush
    // is dropped.
    logic idle, if_busy, lsb_busy, if_new, lsb_new, if_req, lsb_req;
    logic grant_if, grant_lsb;

    assign idle     = (state_q == ST_IDLE);
    assign if_busy  = if_pend_q | (state_q == ST_FETCH);
    assign lsb_busy = lsb_pend_q | (state_q == ST_LOAD) | (state_q == ST_STORE);
    assign if_new   = bus.in_if_flag & ~if_busy & ~bus.in_rob_xbp;
    assign lsb_new  = bus.in_lsb_flag & ~lsb_busy;
    assign if_req   = (if_pend_q & ~bus.in_rob_xbp) | if_new;
    assign lsb_req  = lsb_pend_q | lsb_new;

    // On a collision the LSB wins unless it was the last one served.
    assign grant_lsb = idle & lsb_req & (~if_req | (last_served_q == LAST_IF));
    assign grant_if  = idle & if_req & ~grant_lsb;

    // A granted request comes from its latch if pending, else straight
    // from the pulse inputs.
    DATA_TYPE   g_pc, g_addr, g_data;
    logic       g_wr, g_io;
    logic [1:0] g_size;

    assign g_pc   = if_pend_q  ? if_pc_q    : bus.in_if_pc;
    assign g_addr = lsb_pend_q ? lsb_addr_q : bus.in_lsb_addr;
    assign g_data = lsb_pend_q ? lsb_data_q : bus.in_lsb_data;
    assign g_wr   = lsb_pend_q ? lsb_wr_q   : bus.in_lsb_wr;
    assign g_size = lsb_pend_q ? lsb_size_q : bus.in_lsb_size;
    assign g_io   = (g_addr[17:16] == IO_ADDR_HI);

    // The word being assembled, with the byte on mem_din inserted at cnt_q.
    DATA_TYPE asm_next;
    always_comb begin
        asm_next = asm_q;
        asm_next[{cnt_q, 3'b000} +: 8] = bus.mem_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_served_q  <= LAST_IF;
            if_pend_q      <= 1'b0;
            lsb_pend_q     <= 1'b0;
            if_pc_q        <= '0;
            lsb_wr_q       <= 1'b0;
            lsb_addr_q     <= '0;
            lsb_data_q     <= '0;
            lsb_size_q     <= '0;
            cnt_q          <= '0;
            last_q         <= '0;
            io_q           <= 1'b0;
            asm_q          <= '0;
            wbuf_q         <= '0;
            out_if_flag_q  <= 1'b0;
            out_lsb_flag_q <= 1'b0;
            out_if_inst_q  <= '0;
            out_lsb_data_q <= '0;
            mem_a_q        <= '0;
            mem_dout_q     <= '0;
            mem_wr_q       <= 1'b0;
        end else if (bus.rdy) begin
            out_if_flag_q  <= 1'b0;
            out_lsb_flag_q <= 1'b0;

            if (grant_if || bus.in_rob_xbp) begin
                if_pend_q <= 1'b0;
            end else if (if_new) begin
                if_pend_q <= 1'b1;
                if_pc_q   <= bus.in_if_pc;
            end

            if (grant_lsb) begin
                lsb_pend_q <= 1'b0;
            end else if (lsb_new) begin
                lsb_pend_q <= 1'b1;
                lsb_wr_q   <= bus.in_lsb_wr;
                lsb_addr_q <= bus.in_lsb_addr;
                lsb_size_q <= bus.in_lsb_size;
                lsb_data_q <= bus.in_lsb_data;
            end

            case (state_q)
                ST_IDLE: begin
                    mem_wr_q <= 1'b0;
                    if (grant_lsb) begin
                        last_served_q <= LAST_LSB;
                        mem_a_q       <= g_addr;
                        cnt_q         <= 2'd0;
                        last_q        <= size_to_last(g_size);
                        asm_q         <= '0;
                        if (g_wr) begin
                            state_q    <= ST_STORE;
                            io_q       <= g_io;
                            mem_dout_q <= g_data[7:0];
                            wbuf_q     <= g_data >> 8;
                            mem_wr_q   <= ~(g_io & bus.io_buffer_full);
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end else if (grant_if) begin
                        last_served_q <= LAST_IF;
                        state_q       <= ST_FETCH;
                        mem_a_q       <= g_pc;
                        cnt_q         <= 2'd0;
                        last_q        <= 2'd3;
                        asm_q         <= '0;
                    end
                end

                ST_FETCH: begin
                    mem_wr_q <= 1'b0;
                    if (bus.in_rob_xbp) begin
                        state_q <= ST_IDLE;
                    end else begin
                        asm_q <= asm_next;
                        if (cnt_q == last_q) begin
                            out_if_flag_q <= 1'b1;
                            out_if_inst_q <= asm_next;
                            state_q       <= ST_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 2'd1;
                            mem_a_q <= mem_a_q + 32'd1;
                        end
                    end
                end

                ST_LOAD: begin
                    mem_wr_q <= 1'b0;
                    asm_q    <= asm_next;
                    if (cnt_q == last_q) begin
                        out_lsb_flag_q <= 1'b1;
                        out_lsb_data_q <= asm_next;
                        state_q        <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 2'd1;
                        mem_a_q <= mem_a_q + 32'd1;
                    end
                end

                ST_STORE: begin
                    // mem_wr_q high means byte cnt_q went out last cycle;
                    // low means it was held back by a full UART buffer.
                    if (mem_wr_q) begin
                        if (cnt_q == last_q) begin
                            out_lsb_flag_q <= 1'b1;
                            state_q        <= ST_IDLE;
                            mem_wr_q       <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_q + 2'd1;
                            mem_a_q    <= mem_a_q + 32'd1;
                            mem_dout_q <= wbuf_q[7:0];
                            wbuf_q     <= wbuf_q >> 8;
                            mem_wr_q   <= ~(io_q & bus.io_buffer_full);
                        end
                    end else begin
                        mem_wr_q <= ~(io_q & bus.io_buffer_full);
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_if_flag  = out_if_flag_q;
    assign bus.out_if_inst  = out_if_inst_q;
    assign bus.out_lsb_flag = out_lsb_flag_q;
    assign bus.out_lsb_data = out_lsb_data_q;
    assign bus.mem_a        = mem_a_q;
    assign bus.mem_dout     = mem_dout_q;
    assign bus.mem_wr       = mem_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed testbench for mem_arbiter with a scoreboard of
//                expected completions and RAM writes, each tagged with the
//                cycle in which it must appear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct { logic [31:0] data; int cyc; bit chk; } done_t;
    typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   g;

    done_t if_exp[$];
    done_t lsb_exp[$];
    wr_t   wr_exp[$];

    logic [7:0] ram [0:65535];

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: 64 KiB image, combinational read of the current address.
    always @(posedge clk) if (bus.mem_wr === 1'b1) ram[bus.mem_a[15:0]] <= bus.mem_dout;
    assign bus.mem_din = ram[bus.mem_a[15:0]];

    // Monitor / scoreboard
    always @(negedge clk) begin
        done_t e;
        wr_t   w;
        if (!rst) begin
            if (bus.out_if_flag === 1'b1) begin
                checks++;
                if (if_exp.size() == 0) begin
                    errors++;
                    $display("FAIL if_done: unexpected pulse at cycle %0d inst %h, required none", cyc, bus.out_if_inst);
                end else begin
                    e = if_exp.pop_front();
                    if (e.cyc != cyc || bus.out_if_inst !== e.data) begin
                        errors++;
                        $display("FAIL if_done: cycle %0d inst %h, required cycle %0d inst %h", cyc, bus.out_if_inst, e.cyc, e.data);
                    end
                end
            end
            if (bus.out_lsb_flag === 1'b1) begin
                checks++;
                if (lsb_exp.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_done: unexpected pulse at cycle %0d data %h, required none", cyc, bus.out_lsb_data);
                end else begin
                    e = lsb_exp.pop_front();
                    if (e.cyc != cyc || (e.chk && bus.out_lsb_data !== e.data)) begin
                        errors++;
                        $display("FAIL lsb_done: cycle %0d data %h, required cycle %0d data %h", cyc, bus.out_lsb_data, e.cyc, e.data);
                    end
                end
            end
            if (bus.mem_wr === 1'b1) begin
                checks++;
                if (wr_exp.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write: unexpected write cycle %0d addr %h data %h, required none", cyc, bus.mem_a, bus.mem_dout);
                end else begin
                    w = wr_exp.pop_front();
                    if (w.cyc != cyc || bus.mem_a !== w.a || bus.mem_dout !== w.d) begin
                        errors++;
                        $display("FAIL mem_write: cycle %0d addr %h data %h, required cycle %0d addr %h data %h",
                                 cyc, bus.mem_a, bus.mem_dout, w.cyc, w.a, w.d);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Presents one-cycle request pulses; they are sampled at edge cyc+1.
    task automatic issue(input bit f, input logic [31:0] pc,
                         input bit l, input bit wr, input logic [31:0] addr,
                         input logic [1:0] sz, input logic [31:0] data);
        bus.in_if_flag  = f;
        bus.in_if_pc    = pc;
        bus.in_lsb_flag = l;
        bus.in_lsb_wr   = wr;
        bus.in_lsb_addr = addr;
        bus.in_lsb_size = sz;
        bus.in_lsb_data = data;
        @(posedge clk); #1;
        bus.in_if_flag  = 1'b0;
        bus.in_lsb_flag = 1'b0;
    endtask

    // Waits for every expected event, then idles a few cycles so a stray
    // pulse would still reach the monitor.
    task automatic drain(input string name);
        int n = 0;
        while ((if_exp.size() + lsb_exp.size() + wr_exp.size()) != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL %s: timeout with %0d if / %0d lsb / %0d writes outstanding, required 0",
                     name, if_exp.size(), lsb_exp.size(), wr_exp.size());
            if_exp.delete();
            lsb_exp.delete();
            wr_exp.delete();
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
        ram[16'h1004] = 8'h93; ram[16'h1005] = 8'h00; ram[16'h1006] = 8'h10; ram[16'h1007] = 8'h00;
        ram[16'h2000] = 8'h34; ram[16'h2001] = 8'h12; ram[16'h2002] = 8'h00; ram[16'h2003] = 8'h80;
        ram[16'h2010] = 8'h7E;

        bus.rdy = 1'b1;
        bus.in_if_flag = 1'b0;  bus.in_if_pc = '0;
        bus.in_lsb_flag = 1'b0; bus.in_lsb_wr = 1'b0; bus.in_lsb_addr = '0;
        bus.in_lsb_size = '0;   bus.in_lsb_data = '0;
        bus.in_rob_xbp = 1'b0;  bus.io_buffer_full = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_if_flag",  {31'd0, bus.out_if_flag},  32'd0);
        chk("rst_out_if_inst",  bus.out_if_inst,            32'd0);
        chk("rst_out_lsb_flag", {31'd0, bus.out_lsb_flag}, 32'd0);
        chk("rst_out_lsb_data", bus.out_lsb_data,           32'd0);
        chk("rst_mem_a",        bus.mem_a,                  32'd0);
        chk("rst_mem_dout",     {24'd0, bus.mem_dout},      32'd0);
        chk("rst_mem_wr",       {31'd0, bus.mem_wr},        32'd0);
        @(posedge clk); #1;

        // Fetch 0x1000 -> 0x00000513 after G+4, address walk 0x1000..0x1003
        g = cyc + 1;
        if_exp.push_back('{data: 32'h00000513, cyc: g + 4, chk: 1'b1});
        issue(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, SZ_BYTE, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fetch_mem_a", bus.mem_a, 32'h1000 + k);
        end
        drain("fetch");

        // Collision, last served = fetch: byte load first, fetch after
        g = cyc + 1;
        lsb_exp.push_back('{data: 32'h00000080, cyc: g + 1, chk: 1'b1});
        if_exp.push_back('{data: 32'h00100093, cyc: g + 6, chk: 1'b1});
        issue(1'b1, 32'h1004, 1'b1, 1'b0, 32'h2003, SZ_BYTE, 32'h0);
        drain("collision_lsb_first");

        // Lone byte load 0x2003 -> 0x80 after G+1
        g = cyc + 1;
        lsb_exp.push_back('{data: 32'h00000080, cyc: g + 1, chk: 1'b1});
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h2003, SZ_BYTE, 32'h0);
        drain("byte_load");

        // Collision, last served = LSB: fetch first, half load 0x1234 after
        g = cyc + 1;
        if_exp.push_back('{data: 32'h00000513, cyc: g + 4, chk: 1'b1});
        lsb_exp.push_back('{data: 32'h00001234, cyc: g + 7, chk: 1'b1});
        issue(1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, SZ_HALF, 32'h0);
        drain("collision_if_first");

        // Store word 0xDEADBEEF at 0x2000: EF BE AD DE on G..G+3, done G+4
        g = cyc + 1;
        wr_exp.push_back('{a: 32'h2000, d: 8'hEF, cyc: g});
        wr_exp.push_back('{a: 32'h2001, d: 8'hBE, cyc: g + 1});
        wr_exp.push_back('{a: 32'h2002, d: 8'hAD, cyc: g + 2});
        wr_exp.push_back('{a: 32'h2003, d: 8'hDE, cyc: g + 3});
        lsb_exp.push_back('{data: 32'h0, cyc: g + 4, chk: 1'b0});
        issue(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, SZ_WORD, 32'hDEADBEEF);
        drain("store_word");

        // Word load reads the stored value back
        g = cyc + 1;
        lsb_exp.push_back('{data: 32'hDEADBEEF, cyc: g + 4, chk: 1'b1});
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, SZ_WORD, 32'h0);
        drain("word_load");

        // Flush sampled at G+3 (third fetch byte): no fetch completion;
        // the LSB load latched at G+1 is granted at G+4, done at G+5.
        g = cyc + 1;
        lsb_exp.push_back('{data: 32'h0000007E, cyc: g + 5, chk: 1'b1});
        issue(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, SZ_BYTE, 32'h0);
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h2010, SZ_BYTE, 32'h0);
        @(posedge clk); #1;
        bus.in_rob_xbp = 1'b1;
        @(posedge clk); #1;
        bus.in_rob_xbp = 1'b0;
        drain("flush");

        // IO byte store with a full UART buffer over edges G..G+2:
        // write held for three cycles, issued on G+3, done at G+4.
        g = cyc + 1;
        wr_exp.push_back('{a: 32'h00030000, d: 8'h5A, cyc: g + 3});
        lsb_exp.push_back('{data: 32'h0, cyc: g + 4, chk: 1'b0});
        bus.io_buffer_full = 1'b1;
        issue(1'b0, 32'h0, 1'b1, 1'b1, 32'h00030000, SZ_BYTE, 32'h0000005A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.io_buffer_full = 1'b0;
        drain("io_store");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Owns the single byte-wide RAM port and shares it between the fetcher (32-bit instruction reads on icache miss) and the LSB (1/2/4-byte loads and stores). Requesters issue one-cycle request pulses. The arbiter latches and grants them, then sequences the multi-byte transfer one byte per cycle in little-endian order. It returns a one-cycle completion pulse with the assembled data. A ROB misprediction flush cancels instruction fetches; LSB transactions always run to completion.

## Interface
- No parameters. Constants come from the shared definition header.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: when low, all state and outputs hold.
- `in_if_flag` in 1: fetch request pulse.
- `in_if_pc` in 32: fetch address.
- `out_if_flag` out 1: fetch done pulse.
- `out_if_inst` out 32: fetched word.
- `in_lsb_flag` in 1: LSB request pulse.
- `in_lsb_wr` in 1: 1 = store, 0 = load.
- `in_lsb_addr` in 32: LSB byte address.
- `in_lsb_size` in 2: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes.
- `in_lsb_data` in 32: store data.
- `out_lsb_flag` out 1: LSB done pulse, for loads and stores.
- `out_lsb_data` out 32: load data, zero-extended.
- `in_rob_xbp` in 1: misprediction flush.
- `mem_din` in 8: RAM read byte. It reflects the `mem_a` of the previous cycle.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM address.
- `mem_wr` out 1: RAM write enable.
- `io_buffer_full` in 1: UART buffer full.

## Operation
- Pending latches:
  - A request pulse sets `if_pend` or `lsb_pend`, together with its address, size and data.
  - A pending request is cleared when it is granted.
  - A request pulse arriving while the same requester is pending or in flight is a protocol error. It is ignored.
- States:
  - IDLE: grant logic runs here.
  - FETCH: 4-byte read.
  - LOAD: n-byte read.
  - STORE: n-byte write.
- Grant, evaluated in IDLE on the sampled pulse or pending latch:
  - If only one requester is pending, grant it.
  - If both are pending, use round-robin on the last-served requester; after reset the last-served is fetch, so the LSB wins first.
  - A pulse sampled in IDLE is granted at that same edge without passing through the latch.
- Read sequencing, n = 4 for fetch:
  - At the grant edge G, `mem_a` = addr.
  - At edge G+k, `mem_a` = addr+k, for k < n.
  - Byte k is captured from `mem_din` at edge G+1+k into bits [8k+7:8k].
- Write sequencing:
  - At edge G+k, drive `mem_a` = addr+k, `mem_dout` = data[8k+7:8k] and `mem_wr` = 1.
  - IO stall: if addr[17:16] == 2'b11 and `io_buffer_full` = 1, drive `mem_wr` = 0 and do not advance k; retry next cycle.
- Completion:
  - The done pulse is registered at the edge that captures the last byte for reads, or at the edge after the last write byte for stores.
  - The state returns to IDLE at that same edge.
  - `mem_wr` returns to 0 whenever the arbiter is not in STORE.
- Flush (`in_rob_xbp` = 1):
  - Clear `if_pend`.
  - If in FETCH, abort to IDLE at that edge with no `out_if_flag`.
  - A fetch pulse arriving in the same cycle as the flush is dropped.
  - LOAD and STORE are unaffected.

## Timing
- Reset values:
  - All outputs 0; `mem_a` = 0.
  - State = IDLE, both pending latches = 0, last-served = fetch.
- Fetch latency: pulse sampled at edge T with the arbiter idle → `out_if_flag` is high in the cycle after edge T+4.
- Load latency: size n → `out_lsb_flag` after edge T+n.
- Store latency: size n → `out_lsb_flag` after edge T+n, when there is no IO stall.
- Done flags are single-cycle pulses.
- Data outputs hold their value until the next completion.
- Minimum gap: a new grant can occur at the edge after a completion edge.
- A reset in mid-transfer aborts it immediately:
  - no done pulse;
  - `mem_wr` = 0 on the next cycle.

## Structure
- Shared definition header:
  - state encodings;
  - size encodings;
  - the IO address bits 17:16 == 2'b11;
  - `DATA_TYPE`.
- Single flat module, no sub-module. The byte counter, shift/assemble register and grant logic all live inline.

## Test plan
- Fetch at pc 0x1000, RAM holds 0x00000513 → `out_if_flag` after edge T+4 with `out_if_inst` = 0x00000513, and `mem_a` sequence 0x1000..0x1003.
- LSB byte load at 0x2003, RAM byte 0x80 → `out_lsb_data` = 0x00000080 after T+1; half-word load returns correct little-endian order.
- Store word 0xDEADBEEF at 0x2000 → writes EF, BE, AD, DE to 0x2000..0x2003 on consecutive cycles, then `out_lsb_flag`.
- Fetch and LSB pulses arrive in the same idle cycle → LSB served first, fetch next. Repeat the collision → fetch served first.
- Flush during the 3rd fetch byte → no `out_if_flag`; a pending LSB load then completes normally.
- Byte store to 0x30000 with `io_buffer_full` high for 3 cycles → `mem_wr` low for 3 cycles, then one write, then `out_lsb_flag`.
